// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder, operands consumed LSB first,
// carry kept in a flop between bits, result handed off with valid/ready.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-2:0] sum_sh_reg;
  logic [WIDTH-2:0] sum_sh_next;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             overflow_reg;
  logic [WIDTH-1:0] b_load;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a  (a_sh_reg[0]),
    .b  (b_sh_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  // Subtraction is A + ~B + 1: invert B at load time, carry seeded with 1.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bsel
      assign b_load[gi] = b[gi] ^ op_sub;
    end
    // Partial sum holds WIDTH-1 bits; the MSB goes straight into sum_reg.
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_sum
      if (gi == WIDTH - 2) begin : g_top
        assign sum_sh_next[gi] = fa_s;
      end else begin : g_mid
        assign sum_sh_next[gi] = sum_sh_reg[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      a_sh_reg     <= '0;
      b_sh_reg     <= '0;
      sum_sh_reg   <= '0;
      sum_reg      <= '0;
      carry_reg    <= 1'b0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b_load;
            carry_reg  <= op_sub ? 1'b1 : cin;
            cnt_reg    <= '0;
            sum_sh_reg <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          sum_sh_reg <= sum_sh_next;
          carry_reg  <= fa_co;
          if (cnt_reg == LAST_BIT) begin
            // carry_reg here is the carry into the MSB
            sum_reg      <= {fa_s, sum_sh_reg};
            cout_reg     <= fa_co;
            overflow_reg <= carry_reg ^ fa_co;
            state_reg    <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign overflow  = overflow_reg;

endmodule
